// File: rtl/ula_seq_acc_pkg.sv
// ula_seq_acc_pkg -- shared FSM state, ALU op codes and status-flag bit positions.
// Rev 1.0
`default_nettype none

package ula_seq_acc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_NOT = 4'b0011;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_SUB = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_SHR = 4'b0111;
    localparam logic [3:0] OP_ROL = 4'b1000;
    localparam logic [3:0] OP_ROR = 4'b1001;

    localparam int FLAG_C = 3;
    localparam int FLAG_V = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam int CMD_W = 9;

    function automatic logic [3:0] load_flags(input logic [3:0] value);
        logic [3:0] f;
        f         = '0;
        f[FLAG_Z] = (value == 4'd0);
        f[FLAG_N] = value[3];
        return f;
    endfunction

    // Logic, shift and rotate ops leave carry/overflow untouched when flag hold is enabled.
    function automatic logic is_flag_hold_op(input logic [3:0] op);
        logic hold;
        case (op)
            OP_ADD, OP_SUB:                   hold = 1'b0;
            OP_AND, OP_OR, OP_XOR, OP_NOT,
            OP_SHL, OP_SHR, OP_ROL, OP_ROR:   hold = 1'b1;
            default:                          hold = 1'b0;
        endcase
        return hold;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ula_seq_acc_fifo.sv
// ula_cmd_fifo -- first-word-fall-through command FIFO, DEPTH entries of WIDTH bits.
// Rev 1.0
`default_nettype none

module ula_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Power-of-two depth lets the pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      count_q <= count_q + CW'(1);
            else if (do_pop && !do_push) count_q <= count_q - CW'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/ula_seq_acc.sv
// ula_seq_acc -- queued accumulator sequencer driving an external combinational ALU.
// Optional macro ULA_SEQ_ACC_FLAG_HOLD_EN keeps C/V on logic/shift/rotate ops. Rev 1.0
`default_nettype none

module ula_seq_acc
    import ula_seq_acc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_load,
    input  logic [3:0] cmd_op,
    input  logic [3:0] cmd_operand,
    output logic [3:0] alu_a_out,
    output logic [3:0] alu_b_out,
    output logic [3:0] alu_op_out,
    input  logic [3:0] alu_res_in,
    input  logic       alu_c_in,
    input  logic       alu_v_in,
    input  logic       alu_z_in,
    input  logic       alu_n_in,
    output logic [3:0] acc_out,
    output logic [3:0] flags_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic       busy
);

    state_t           state_q;
    logic             ready_en_q;
    logic [3:0]       acc_q;
    logic [3:0]       flags_q;
    logic [3:0]       alu_a_q;
    logic [3:0]       alu_b_q;
    logic [3:0]       alu_op_q;
    logic             load_q;
    logic             rsp_valid_q;
    logic [3:0]       acc_d;
    logic [3:0]       flags_d;
    logic [3:0]       alu_flags;
    logic [CMD_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_push;
    logic             fifo_pop;

    // Ready stays low through reset and rises on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_en_q <= 1'b0;
        else        ready_en_q <= 1'b1;
    end

    assign cmd_ready = ready_en_q & ~fifo_full;
    assign fifo_push = cmd_valid & cmd_ready;
    assign fifo_pop  = (state_q == ST_IDLE) & ~fifo_empty;

    ula_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   ({cmd_load, cmd_op, cmd_operand}),
        .pop_i   (fifo_pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign alu_flags[FLAG_C] = alu_c_in;
    assign alu_flags[FLAG_V] = alu_v_in;
    assign alu_flags[FLAG_Z] = alu_z_in;
    assign alu_flags[FLAG_N] = alu_n_in;

    always_comb begin
        acc_d   = load_q ? alu_b_q : alu_res_in;
        flags_d = alu_flags;
        if (load_q) begin
            flags_d = load_flags(alu_b_q);
        end
`ifdef ULA_SEQ_ACC_FLAG_HOLD_EN
        else if (is_flag_hold_op(alu_op_q)) begin
            flags_d[FLAG_C] = flags_q[FLAG_C];
            flags_d[FLAG_V] = flags_q[FLAG_V];
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            flags_q     <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            load_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        alu_a_q  <= acc_q;
                        alu_b_q  <= fifo_dout[3:0];
                        alu_op_q <= fifo_dout[7:4];
                        load_q   <= fifo_dout[8];
                        state_q  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    acc_q       <= acc_d;
                    flags_q     <= flags_d;
                    rsp_valid_q <= 1'b1;
                    state_q     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_a_out  = alu_a_q;
    assign alu_b_out  = alu_b_q;
    assign alu_op_out = alu_op_q;
    assign acc_out    = acc_q;
    assign flags_out  = flags_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = acc_q;
    assign rsp_flags  = flags_q;
    assign busy       = (state_q != ST_IDLE) | ~fifo_empty;

endmodule

`default_nettype wire

// File: tb/tb_ula_seq_acc.sv
// tb_ula_seq_acc -- directed bench with a behavioural ALU, an in-order reference model and a response monitor.
`default_nettype none

module tb_ula_seq_acc;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid, cmd_ready, cmd_load;
    logic [3:0] cmd_op, cmd_operand;
    logic [3:0] alu_a_out, alu_b_out, alu_op_out;
    logic [3:0] alu_res_in;
    logic       alu_c_in, alu_v_in, alu_z_in, alu_n_in;
    logic [3:0] acc_out, flags_out;
    logic       rsp_valid, rsp_ready;
    logic [3:0] rsp_result, rsp_flags;
    logic       busy;
    logic [7:0] alu_vec;

    always #5 clk = ~clk;

    ula_seq_acc #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_load(cmd_load),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .alu_a_out(alu_a_out), .alu_b_out(alu_b_out), .alu_op_out(alu_op_out),
        .alu_res_in(alu_res_in), .alu_c_in(alu_c_in), .alu_v_in(alu_v_in),
        .alu_z_in(alu_z_in), .alu_n_in(alu_n_in),
        .acc_out(acc_out), .flags_out(flags_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .busy(busy)
    );

    // Behavioural ALU: returns {result[3:0], C, V, Z, N}.
    function automatic logic [7:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
        logic [4:0] s;
        logic [3:0] r;
        logic       c, v;
        r = 4'd0; c = 1'b0; v = 1'b0; s = 5'd0;
        case (op)
            4'd0: r = a & b;
            4'd1: r = a | b;
            4'd2: r = a ^ b;
            4'd3: r = ~a;
            4'd4: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[3:0];
                c = s[4];
                v = (a[3] == b[3]) && (r[3] != a[3]);
            end
            4'd5: begin
                r = a - b;
                c = (a >= b);
                v = (a[3] != b[3]) && (r[3] != a[3]);
            end
            4'd6: begin r = {a[2:0], 1'b0}; c = a[3]; end
            4'd7: begin r = {1'b0, a[3:1]}; c = a[0]; end
            4'd8: r = {a[2:0], a[3]};
            4'd9: r = {a[0], a[3:1]};
            default: r = 4'd0;
        endcase
        return {r, c, v, (r == 4'd0), r[3]};
    endfunction

    always_comb alu_vec = alu_f(alu_a_out, alu_b_out, alu_op_out);
    assign alu_res_in = alu_vec[7:4];
    assign alu_c_in   = alu_vec[3];
    assign alu_v_in   = alu_vec[2];
    assign alu_z_in   = alu_vec[1];
    assign alu_n_in   = alu_vec[0];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: commands complete strictly in acceptance order.
    logic [3:0] m_acc   = 4'd0;
    logic [3:0] m_flags = 4'd0;
    logic [7:0] expq[$];

    function automatic void model_cmd(input logic ld, input logic [3:0] op, input logic [3:0] opnd);
        logic [7:0] v;
        if (ld) begin
            m_acc   = opnd;
            m_flags = {2'b00, (opnd == 4'd0), opnd[3]};
        end else begin
            v     = alu_f(m_acc, opnd, op);
            m_acc = v[7:4];
`ifdef ULA_SEQ_ACC_FLAG_HOLD_EN
            if ((op <= 4'd3) || (op >= 4'd6 && op <= 4'd9)) m_flags = {m_flags[3:2], v[1:0]};
            else                                            m_flags = v[3:0];
`else
            m_flags = v[3:0];
`endif
        end
        expq.push_back({m_acc, m_flags});
    endfunction

    // rsp_ready only changes just after a rising edge, so its negedge value is the one the DUT sees.
    always @(negedge clk) begin
        if (rst_n && rsp_valid) begin
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got result %0h flags %0h expected no response", rsp_result, rsp_flags);
            end else begin
                chk("rsp_result", rsp_result, expq[0][7:4]);
                chk("rsp_flags", rsp_flags, expq[0][3:0]);
                chk("acc_out", acc_out, expq[0][7:4]);
                chk("flags_out", flags_out, expq[0][3:0]);
                if (rsp_ready) void'(expq.pop_front());
            end
        end
    end

    task automatic send(input logic ld, input logic [3:0] op, input logic [3:0] opnd,
                        input int max_wait, output bit ok);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_load = ld; cmd_op = op; cmd_operand = opnd;
        ok = 1'b0;
        for (int i = 0; i < max_wait; i++) begin
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            model_cmd(ld, op, opnd);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic [3:0] r, output logic [3:0] f, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rsp_valid && n < 50);
        if (!rsp_valid) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: got no rsp_valid expected one within 50 cycles");
        end
        r = rsp_result;
        f = rsp_flags;
    endtask

    task automatic do_cmd(input logic ld, input logic [3:0] op, input logic [3:0] opnd,
                          output logic [3:0] r, output logic [3:0] f);
        bit ok;
        int n;
        send(ld, op, opnd, 20, ok);
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got ready low expected command accepted");
        end
        wait_rsp(r, f, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] r, f;
        int         n, accepted;
        bit         ok;

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_load = 1'b0; cmd_op = 4'd0; cmd_operand = 4'd0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_acc", acc_out, 0);
        chk("rst_flags", flags_out, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_alu_a", alu_a_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", cmd_ready, 1);

        // Load 5: response appears on the third edge counting the push edge.
        send(1'b1, 4'd0, 4'd5, 20, ok);
        wait_rsp(r, f, n);
        chk("latency", n, 3);
        chk("load5_result", r, 4'b0101);
        chk("load5_flags", f, 4'b0000);

        do_cmd(1'b1, 4'd0, 4'd7, r, f);
        do_cmd(1'b0, 4'b0100, 4'd1, r, f);
        chk("add_alu_a", alu_a_out, 4'b0111);
        chk("add_alu_b", alu_b_out, 4'b0001);
        chk("add_alu_op", alu_op_out, 4'b0100);
        chk("add_result", r, 4'b1000);
        chk("add_flags", f, 4'b0101);

        do_cmd(1'b1, 4'd0, 4'd3, r, f);
        do_cmd(1'b0, 4'b0101, 4'd5, r, f);
        chk("sub_result", r, 4'b1110);
        chk("sub_flags", f, 4'b0001);

        do_cmd(1'b1, 4'd0, 4'd15, r, f);
        do_cmd(1'b0, 4'b0100, 4'd1, r, f);
        chk("wrap_result", r, 4'b0000);
        chk("wrap_flags", f, 4'b1010);
        do_cmd(1'b0, 4'b0000, 4'd0, r, f);
        chk("and_result", r, 4'b0000);
`ifdef ULA_SEQ_ACC_FLAG_HOLD_EN
        chk("and_flags_hold", f, 4'b1010);
`else
        chk("and_flags", f, 4'b0010);
`endif

        do_cmd(1'b1, 4'd0, 4'd9, r, f);
        chk("load9_flags", f, 4'b0001);
        do_cmd(1'b0, 4'b1111, 4'd3, r, f);
        chk("undef_op_result", r, 4'b0000);
        chk("undef_op_flags", f, 4'b0010);
        chk("undef_op_alu_op", alu_op_out, 4'b1111);

        // Backpressure: one in flight plus a full FIFO.
        @(posedge clk); #1 rsp_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(1'b1, 4'd0, 4'(i + 1), 8, ok);
            if (ok) accepted++;
        end
        chk("bp_accepted", accepted, DEPTH + 1);
        chk("bp_cmd_ready", cmd_ready, 0);
        chk("bp_busy", busy, 1);
        chk("bp_rsp_hold", rsp_result, 4'd1);
        @(posedge clk); #1 rsp_ready = 1'b1;
        n = 0;
        while ((busy || rsp_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_drained", busy, 0);
        chk("bp_queue_left", expq.size(), 0);
        chk("bp_last_acc", acc_out, DEPTH + 1);

        // Reset while the first command executes and another waits in the FIFO.
        send(1'b1, 4'd0, 4'd9, 20, ok);
        send(1'b1, 4'd0, 4'd10, 20, ok);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_acc", acc_out, 0);
        chk("mid_rst_flags", flags_out, 0);
        chk("mid_rst_alu_a", alu_a_out, 0);
        chk("mid_rst_alu_b", alu_b_out, 0);
        chk("mid_rst_alu_op", alu_op_out, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_rsp_result", rsp_result, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_busy", busy, 0);
        expq.delete();
        m_acc = 4'd0;
        m_flags = 4'd0;
        @(negedge clk) rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_busy", busy, 0);
        chk("post_rst_rsp_valid", rsp_valid, 0);
        do_cmd(1'b1, 4'd0, 4'd6, r, f);
        chk("post_rst_load6", r, 4'd6);
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ula_seq_acc.md
ULA_SEQ_ACC -- requirements
Module: ula_seq_acc

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command FIFO entries; power of two, 2..16.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 cmd_valid  in  1  command offered; cmd_ready  out  1  FIFO can accept.
REQ-005 cmd_load  in  1  1 = load operand into accumulator, 0 = ALU operation.
REQ-006 cmd_op  in  4  ALU op code; cmd_operand  in  4  B operand or load value.
REQ-007 alu_a_out, alu_b_out, alu_op_out  out  4 each  registered drive to the combinational ALU.
REQ-008 alu_res_in  in  4; alu_c_in, alu_v_in, alu_z_in, alu_n_in  in  1 each  ALU result and flags.
REQ-009 acc_out  out  4  accumulator; flags_out  out  4  {C,V,Z,N} status register.
REQ-010 rsp_valid  out  1; rsp_ready  in  1; rsp_result  out  4; rsp_flags  out  4  {C,V,Z,N}.
REQ-011 busy  out  1  high whenever FSM is not IDLE or FIFO is non-empty.

Function
REQ-012 Push occurs on an edge with cmd_valid & cmd_ready; cmd_ready = FIFO not full; a pop in the same cycle does not enable a push into a full FIFO.
REQ-013 FSM states IDLE, EXEC, RESP; IDLE->EXEC on an edge with FIFO non-empty (pop at that edge); EXEC->RESP unconditionally; RESP->IDLE on an edge with rsp_ready.
REQ-014 On the IDLE->EXEC edge: alu_a_out<=acc, alu_b_out<=operand, alu_op_out<=op; these hold through EXEC and RESP until the next EXEC entry.
REQ-015 On the EXEC->RESP edge, ALU command: acc<=alu_res_in, flags<=ALU flags; load command: acc<=operand, C=0, V=0, Z=(operand==0), N=operand[3]; ALU inputs ignored.
REQ-016 rsp_result/rsp_flags equal acc_out/flags_out; rsp_valid high exactly in RESP, held stable until rsp_ready.
REQ-017 Latency: a command pushed into an empty FIFO with FSM IDLE gives rsp_valid 3 edges after the push edge (push, pop, capture).
REQ-018 Op codes 1010..1111 pass to the ALU unchanged; the block captures whatever the ALU returns (result 0, Z=1).
REQ-019 Arithmetic wraps modulo 16 as the ALU produces; the block adds no width extension.
REQ-020 FIFO pointers wrap modulo FIFO_DEPTH; count 0..FIFO_DEPTH; order strictly first-in first-out.
REQ-021 While in RESP with rsp_ready low, the FIFO keeps accepting until full; no command is lost or reordered.

Reset
REQ-022 rst_n low asynchronously forces FSM to IDLE, FIFO empty, acc_out, flags_out, alu_*_out and rsp_* to 0, and rsp_valid low.
REQ-023 cmd_ready is 0 while rst_n is low and 1 from the first edge after release.
REQ-024 Reset during EXEC or RESP discards the in-flight and all queued commands; no response is produced for them.

Configuration
REQ-025 With ULA_SEQ_ACC_FLAG_HOLD_EN defined, ALU commands with op 0000-0011 or 0110-1001 update only Z and N; C and V keep their previous values.
REQ-026 Without ULA_SEQ_ACC_FLAG_HOLD_EN, all four flags are taken from the ALU on every ALU command.

Structure
REQ-027 A shared package holds the FSM state enum, op-code constants 0000-1001, and flag bit positions C=3, V=2, Z=1, N=0.
REQ-028 The FIFO is a sub-module, ula_cmd_fifo, 9 bits wide {load, op, operand}, parameterised by FIFO_DEPTH.

Verification
REQ-029 Reset; load 5 -> rsp_result=0101, rsp_flags=0000.
REQ-030 Load 7, then op 0100 with operand 1 -> alu_a_out=0111, alu_b_out=0001; result 1000, flags C0 V1 Z0 N1.
REQ-031 Acc=3, op 0101 with operand 5 -> result 1110, flags C0 V0 Z0 N1.
REQ-032 rsp_ready=0; offer FIFO_DEPTH+2 commands -> exactly FIFO_DEPTH+1 accepted, cmd_ready low; raising rsp_ready drains them in order.
REQ-033 Acc=15, add 1 (C=1), then AND operand 0 -> with the macro flags 1010; without it 0010.
REQ-034 Assert rst_n during EXEC -> all outputs 0 immediately, no response after release, FIFO empty.
